nexys_input_periph: RTL

Memory-mapped input peripheral for `riscv_unit` on the Nexys board: the input-side counterpart of the seven-segment output path. Synchronizes and debounces the 16 slide switches and 5 push buttons, and exposes their stable state to the CPU over the core's data-bus request interface. Records sticky change events and raises a maskable interrupt line.

---
 rtl/nexys_input_pkg.sv | 21 ++
 rtl/input_debouncer.sv | 52 +++++
 rtl/nexys_input_periph.sv | 127 ++++++++++++
 3 files changed

// File: rtl/nexys_input_pkg.sv
// Shared constants for the Nexys input peripheral.
//   Register byte offsets, event-register field layout and a helper that
//   turns a byte offset into the word index decoded from addr_i[4:2].
package nexys_input_pkg;

  localparam int unsigned SW_W        = 16;
  localparam int unsigned BTN_W       = 5;
  localparam int unsigned EVT_W       = SW_W + BTN_W;
  localparam int unsigned EVT_BTN_LSB = 16;

  localparam logic [4:0] ADDR_SW   = 5'h00;
  localparam logic [4:0] ADDR_BTN  = 5'h04;
  localparam logic [4:0] ADDR_EVT  = 5'h08;
  localparam logic [4:0] ADDR_CLR  = 5'h0C;
  localparam logic [4:0] ADDR_MASK = 5'h10;

  function automatic logic [2:0] word_idx(input logic [4:0] byte_off);
    return byte_off[4:2];
  endfunction

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchronizer plus tick-sampled debouncer for W independent inputs.
//   clk_i          clock
//   rst_i          synchronous active-high reset
//   tick_i         sample strobe from the shared prescaler
//   raw_i          asynchronous raw inputs
//   stable_o       debounced level (registered)
//   stable_next_o  value stable_o takes on the next edge; lets the parent
//                  flag events on the same edge the level is accepted
module input_debouncer #(
  parameter int unsigned W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         tick_i,
  input  logic [W-1:0] raw_i,
  output logic [W-1:0] stable_o,
  output logic [W-1:0] stable_next_o
);

  logic [W-1:0] sync1_q, sync2_q, sample_q, stable_q, stable_d;
  logic [W-1:0] agree;

  // A bit is accepted only when this tick's sample matches the previous one.
  assign agree = ~(sync2_q ^ sample_q);

  always_comb begin
    stable_d = stable_q;
    if (tick_i) begin
      stable_d = (sync2_q & agree) | (stable_q & ~agree);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      sample_q <= '0;
      stable_q <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      if (tick_i) begin
        sample_q <= sync2_q;
      end
      stable_q <= stable_d;
    end
  end

  assign stable_o      = stable_q;
  assign stable_next_o = stable_d;

endmodule

// File: rtl/nexys_input_periph.sv
// Memory-mapped switch/button input peripheral with sticky events and IRQ.
//   clk_i, rst_i        clock, synchronous active-high reset
//   sw_i, btn_i         raw asynchronous switches / buttons (1 = pressed)
//   req_i               one-cycle bus strobe
//   write_enable_i      1 = write, 0 = read
//   addr_i              byte address, bits [4:2] decoded
//   write_data_i        write data
//   read_data_o         registered read data, 1-cycle latency
//   irq_o               registered level interrupt, |(EVT & MASK)
module nexys_input_periph #(
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned SW_W            = 16,
  parameter int unsigned BTN_W           = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [SW_W-1:0]   sw_i,
  input  logic [BTN_W-1:0]  btn_i,
  input  logic              req_i,
  input  logic              write_enable_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       write_data_i,
  output logic [31:0]       read_data_o,
  output logic              irq_o
);
  import nexys_input_pkg::*;

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned EvtW = EVT_BTN_LSB + BTN_W;

  // Shared prescaler.
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tick;

  assign tick  = (cnt_q == CntW'(DEBOUNCE_CYCLES - 1));
  assign cnt_d = tick ? '0 : cnt_q + CntW'(1);

  logic [SW_W-1:0]  sw_stable, sw_next;
  logic [BTN_W-1:0] btn_stable, btn_next;

  input_debouncer #(.W(SW_W)) u_sw_deb (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .tick_i        (tick),
    .raw_i         (sw_i),
    .stable_o      (sw_stable),
    .stable_next_o (sw_next)
  );

  input_debouncer #(.W(BTN_W)) u_btn_deb (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .tick_i        (tick),
    .raw_i         (btn_i),
    .stable_o      (btn_stable),
    .stable_next_o (btn_next)
  );

  logic [EvtW-1:0] evt_q, evt_d, evt_set, evt_clr;
  logic [EvtW-1:0] mask_q, mask_d;
  logic            irq_q, irq_d;
  logic [31:0]     read_data_q, rd_mux;
  logic [2:0]      word;
  logic            wr, rd;

  assign word = addr_i[4:2];
  assign wr   = req_i & write_enable_i;
  assign rd   = req_i & ~write_enable_i;

  always_comb begin
    evt_set = '0;
    // Switches flag either edge, buttons only the press.
    evt_set[SW_W-1:0]            = sw_next ^ sw_stable;
    evt_set[EVT_BTN_LSB +: BTN_W] = btn_next & ~btn_stable;

    evt_clr = '0;
    if (wr && word == word_idx(ADDR_CLR)) begin
      evt_clr = write_data_i[EvtW-1:0];
    end

    // Set is applied after clear so a coincident set wins.
    evt_d = (evt_q & ~evt_clr) | evt_set;

    mask_d = mask_q;
    if (wr && word == word_idx(ADDR_MASK)) begin
      mask_d = write_data_i[EvtW-1:0];
    end

    irq_d = |(evt_d & mask_d);
  end

  always_comb begin
    rd_mux = '0;
    unique case (word)
      word_idx(ADDR_SW):   rd_mux = 32'(sw_stable);
      word_idx(ADDR_BTN):  rd_mux = 32'(btn_stable);
      word_idx(ADDR_EVT):  rd_mux = 32'(evt_q);
      word_idx(ADDR_MASK): rd_mux = 32'(mask_q);
      default:             rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      evt_q       <= '0;
      mask_q      <= '0;
      irq_q       <= 1'b0;
      read_data_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      evt_q  <= evt_d;
      mask_q <= mask_d;
      irq_q  <= irq_d;
      if (rd) begin
        read_data_q <= rd_mux;
      end
    end
  end

  assign read_data_o = read_data_q;
  assign irq_o       = irq_q;

  logic unused_bits;
  assign unused_bits = ^{addr_i[31:5], addr_i[1:0], write_data_i[31:EvtW]};

endmodule
